// File: rtl/wb_stage_pipe.sv
// Writeback stage: MEM/WB pipeline register, load extraction, writeback mux,
// x0 write gating and a retired-instruction counter.
module wb_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64,
  parameter int OFF_W  = $clog2(XLEN / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_wb,
  input  logic              flush_wb,
  input  logic              valid_mem,
  input  logic [XLEN-1:0]   alu_result_mem,
  input  logic [XLEN-1:0]   load_data_mem,
  input  logic [OFF_W-1:0]  addr_off_mem,
  input  logic [2:0]        load_f3_mem,
  input  logic [XLEN-1:0]   pc_plus4_mem,
  input  logic [XLEN-1:0]   csr_rdata_mem,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              reg_write_mem,
  input  logic [1:0]        wb_sel_mem,
  output logic [XLEN-1:0]   wb_write_data,
  output logic [REG_AW-1:0] wb_write_addr,
  output logic              wb_write_en,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic              valid_reg;
  logic [XLEN-1:0]   alu_reg;
  logic [XLEN-1:0]   load_data_reg;
  logic [OFF_W-1:0]  off_reg;
  logic [2:0]        f3_reg;
  logic [XLEN-1:0]   pc4_reg;
  logic [XLEN-1:0]   csr_reg;
  logic [REG_AW-1:0] rd_reg;
  logic              reg_write_reg;
  logic [1:0]        wb_sel_reg;
  logic [CNT_W-1:0]  instret_reg;
  logic              retire;

  // The WB instruction leaves the stage whenever the register advances;
  // a flush advances it even under stall, so it still retires.
  assign retire = valid_reg & (~stall_wb | flush_wb);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      alu_reg       <= '0;
      load_data_reg <= '0;
      off_reg       <= '0;
      f3_reg        <= '0;
      pc4_reg       <= '0;
      csr_reg       <= '0;
      rd_reg        <= '0;
      reg_write_reg <= 1'b0;
      wb_sel_reg    <= '0;
      instret_reg   <= '0;
    end else begin
      if (flush_wb) begin
        valid_reg <= 1'b0;
      end else if (!stall_wb) begin
        valid_reg     <= valid_mem;
        alu_reg       <= alu_result_mem;
        load_data_reg <= load_data_mem;
        off_reg       <= addr_off_mem;
        f3_reg        <= load_f3_mem;
        pc4_reg       <= pc_plus4_mem;
        csr_reg       <= csr_rdata_mem;
        rd_reg        <= rd_mem;
        reg_write_reg <= reg_write_mem;
        wb_sel_reg    <= wb_sel_mem;
      end
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  // Load extraction: align the addressed lane down to bit 0, then extend.
  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [XLEN-1:0]  sh_b;
  logic [XLEN-1:0]  sh_h;
  logic [XLEN-1:0]  sh_w;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic [31:0]      ld_w;
  logic [XLEN-1:0]  load_val;

  assign off_h = off_reg & ~OFF_W'(1);
  assign off_w = off_reg & ~OFF_W'(3);
  assign sh_b  = load_data_reg >> {off_reg, 3'b000};
  assign sh_h  = load_data_reg >> {off_h, 3'b000};
  assign sh_w  = load_data_reg >> {off_w, 3'b000};
  assign ld_b  = sh_b[7:0];
  assign ld_h  = sh_h[15:0];
  assign ld_w  = sh_w[31:0];

  always_comb begin
    load_val = load_data_reg;
    case (f3_reg)
      3'b000: load_val = XLEN'($signed(ld_b));
      3'b100: load_val = XLEN'(ld_b);
      3'b001: load_val = XLEN'($signed(ld_h));
      3'b101: load_val = XLEN'(ld_h);
      3'b010: load_val = XLEN'($signed(ld_w));
      3'b110: load_val = (XLEN == 64) ? XLEN'(ld_w) : XLEN'($signed(ld_w));
      3'b011: load_val = (XLEN == 64) ? load_data_reg : XLEN'($signed(ld_w));
      default: load_val = load_data_reg;
    endcase
  end

  always_comb begin
    wb_write_data = csr_reg;
    case (wb_sel_reg)
      SEL_ALU:  wb_write_data = alu_reg;
      SEL_LOAD: wb_write_data = load_val;
      SEL_PC4:  wb_write_data = pc4_reg;
      default:  wb_write_data = csr_reg;
    endcase
  end

  assign wb_write_addr = rd_reg;
  assign wb_write_en   = valid_reg & reg_write_reg & (rd_reg != '0);
  assign wb_valid      = valid_reg;
  assign instret       = instret_reg;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: a default XLEN=32 instance and an
// XLEN=64 / CNT_W=4 instance for 64-bit loads and counter wrap.
module tb_wb_stage_pipe;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- XLEN=32 instance ----------------
  logic        a_rst, a_stall, a_flush, a_valid_mem, a_rw;
  logic [31:0] a_alu, a_ld, a_pc4, a_csr;
  logic [1:0]  a_off, a_sel;
  logic [2:0]  a_f3;
  logic [4:0]  a_rd;
  logic [31:0] a_wdata;
  logic [4:0]  a_waddr;
  logic        a_wen, a_wvalid;
  logic [63:0] a_instret;

  wb_stage_pipe dut32 (
    .clk(clk), .rst(a_rst), .stall_wb(a_stall), .flush_wb(a_flush),
    .valid_mem(a_valid_mem), .alu_result_mem(a_alu), .load_data_mem(a_ld),
    .addr_off_mem(a_off), .load_f3_mem(a_f3), .pc_plus4_mem(a_pc4),
    .csr_rdata_mem(a_csr), .rd_mem(a_rd), .reg_write_mem(a_rw),
    .wb_sel_mem(a_sel), .wb_write_data(a_wdata), .wb_write_addr(a_waddr),
    .wb_write_en(a_wen), .wb_valid(a_wvalid), .instret(a_instret)
  );

  // ---------------- XLEN=64, CNT_W=4 instance ----------------
  logic        b_rst, b_stall, b_flush, b_valid_mem, b_rw;
  logic [63:0] b_alu, b_ld, b_pc4, b_csr;
  logic [2:0]  b_off;
  logic [1:0]  b_sel;
  logic [2:0]  b_f3;
  logic [4:0]  b_rd;
  logic [63:0] b_wdata;
  logic [4:0]  b_waddr;
  logic        b_wen, b_wvalid;
  logic [3:0]  b_instret;

  wb_stage_pipe #(.XLEN(64), .REG_AW(5), .CNT_W(4)) dut64 (
    .clk(clk), .rst(b_rst), .stall_wb(b_stall), .flush_wb(b_flush),
    .valid_mem(b_valid_mem), .alu_result_mem(b_alu), .load_data_mem(b_ld),
    .addr_off_mem(b_off), .load_f3_mem(b_f3), .pc_plus4_mem(b_pc4),
    .csr_rdata_mem(b_csr), .rd_mem(b_rd), .reg_write_mem(b_rw),
    .wb_sel_mem(b_sel), .wb_write_data(b_wdata), .wb_write_addr(b_waddr),
    .wb_write_en(b_wen), .wb_valid(b_wvalid), .instret(b_instret)
  );

  // Reference retirement model for the 32-bit instance.
  logic        m_valid;
  logic [63:0] m_ret;

  task automatic tick();
    @(posedge clk);
    if (a_rst) begin
      m_valid = 1'b0;
      m_ret   = 64'd0;
    end else begin
      if (m_valid && (!a_stall || a_flush)) m_ret = m_ret + 64'd1;
      if (a_flush)       m_valid = 1'b0;
      else if (!a_stall) m_valid = a_valid_mem;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %-14s observed %h expected %h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load32(input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] exp, input string tag);
    a_f3  = f3;
    a_off = off;
    tick();
    check(tag, 64'(a_wdata), 64'(exp));
    check({tag, "_ret"}, a_instret, m_ret);
  endtask

  task automatic load64(input logic [2:0] f3, input logic [2:0] off,
                        input logic [63:0] exp, input string tag);
    b_f3  = f3;
    b_off = off;
    tick();
    check(tag, b_wdata, exp);
  endtask

  logic [63:0] saved_ret;

  initial begin
    m_valid = 1'b0;
    m_ret   = 64'd0;
    a_rst = 1'b1; a_stall = 1'b0; a_flush = 1'b0; a_valid_mem = 1'b0; a_rw = 1'b0;
    a_alu = '0; a_ld = '0; a_pc4 = '0; a_csr = '0; a_off = '0; a_sel = '0;
    a_f3 = '0; a_rd = '0;
    b_rst = 1'b1; b_stall = 1'b0; b_flush = 1'b0; b_valid_mem = 1'b0; b_rw = 1'b0;
    b_alu = '0; b_ld = '0; b_pc4 = '0; b_csr = '0; b_off = '0; b_sel = '0;
    b_f3 = '0; b_rd = '0;

    // Reset state
    tick(); tick();
    check("rst_data", 64'(a_wdata), 64'd0);
    check("rst_addr", 64'(a_waddr), 64'd0);
    check("rst_en", 64'(a_wen), 64'd0);
    check("rst_valid", 64'(a_wvalid), 64'd0);
    check("rst_instret", a_instret, 64'd0);

    // ALU writeback, one-cycle latency
    a_rst = 1'b0;
    a_valid_mem = 1'b1; a_sel = 2'b00; a_alu = 32'h0000_1234; a_rd = 5'd5; a_rw = 1'b1;
    tick();
    check("alu_en", 64'(a_wen), 64'd1);
    check("alu_addr", 64'(a_waddr), 64'd5);
    check("alu_data", 64'(a_wdata), 64'h1234);
    check("alu_ret0", a_instret, 64'd0);
    a_valid_mem = 1'b0;
    tick();
    check("alu_ret1", a_instret, 64'd1);
    check("bubble_valid", 64'(a_wvalid), 64'd0);
    check("bubble_en", 64'(a_wen), 64'd0);

    // Loads, XLEN=32
    a_valid_mem = 1'b1; a_sel = 2'b01; a_ld = 32'h80F1_7F82; a_rd = 5'd6;
    load32(3'b000, 2'd0, 32'hFFFF_FF82, "lb_o0");
    load32(3'b100, 2'd1, 32'h0000_007F, "lbu_o1");
    load32(3'b000, 2'd3, 32'hFFFF_FF80, "lb_o3");
    load32(3'b001, 2'd2, 32'hFFFF_80F1, "lh_o2");
    load32(3'b001, 2'd1, 32'h0000_7F82, "lh_o1");
    load32(3'b101, 2'd3, 32'h0000_80F1, "lhu_o3");
    load32(3'b010, 2'd0, 32'h80F1_7F82, "lw");
    load32(3'b011, 2'd2, 32'h80F1_7F82, "ld_as_lw");
    load32(3'b111, 2'd1, 32'h80F1_7F82, "raw");

    // x0 gating and other sources
    a_sel = 2'b00; a_rd = 5'd0; a_rw = 1'b1; a_alu = 32'h5555_0000;
    tick();
    check("x0_en", 64'(a_wen), 64'd0);
    check("x0_valid", 64'(a_wvalid), 64'd1);
    saved_ret = m_ret;
    a_rd = 5'd7; a_sel = 2'b10; a_pc4 = 32'h0000_0104;
    tick();
    check("x0_retired", a_instret, saved_ret + 64'd1);
    check("pc4_data", 64'(a_wdata), 64'h104);
    check("pc4_en", 64'(a_wen), 64'd1);
    a_sel = 2'b11; a_csr = 32'hDEAD_BEEF; a_rw = 1'b0;
    tick();
    check("csr_data", 64'(a_wdata), 64'hDEAD_BEEF);
    check("norw_en", 64'(a_wen), 64'd0);

    // Stall holds A; stall+flush retires A and bubbles
    a_rw = 1'b1; a_sel = 2'b00; a_alu = 32'h0000_A5A5; a_rd = 5'd9;
    tick();
    a_alu = 32'h0000_BBBB; a_rd = 5'd10; a_stall = 1'b1;
    saved_ret = m_ret;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_data", 64'(a_wdata), 64'hA5A5);
      check("stall_addr", 64'(a_waddr), 64'd9);
      check("stall_en", 64'(a_wen), 64'd1);
      check("stall_ret", a_instret, saved_ret);
    end
    a_flush = 1'b1;
    tick();
    check("sf_valid", 64'(a_wvalid), 64'd0);
    check("sf_en", 64'(a_wen), 64'd0);
    check("sf_ret", a_instret, saved_ret + 64'd1);
    a_stall = 1'b0; a_flush = 1'b0;
    tick();
    check("after_sf_data", 64'(a_wdata), 64'hBBBB);
    check("after_sf_addr", 64'(a_waddr), 64'd10);

    // Reset mid-stream with stall+flush active
    a_rst = 1'b1; a_stall = 1'b1; a_flush = 1'b1;
    tick();
    check("mid_rst_valid", 64'(a_wvalid), 64'd0);
    check("mid_rst_ret", a_instret, 64'd0);
    a_rst = 1'b0; a_stall = 1'b0; a_flush = 1'b0; a_valid_mem = 1'b0;

    // XLEN=64 loads
    b_rst = 1'b1;
    tick(); tick();
    b_rst = 1'b0;
    b_valid_mem = 1'b1; b_rw = 1'b1; b_rd = 5'd3; b_sel = 2'b01;
    b_ld = 64'h8000_0000_FFFF_FFFE;
    load64(3'b010, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, "lw64_o0");
    load64(3'b110, 3'd0, 64'h0000_0000_FFFF_FFFE, "lwu64_o0");
    load64(3'b010, 3'd4, 64'hFFFF_FFFF_8000_0000, "lw64_o4");
    load64(3'b011, 3'd5, 64'h8000_0000_FFFF_FFFE, "ld64");
    load64(3'b100, 3'd7, 64'h0000_0000_0000_0080, "lbu64_o7");
    load64(3'b001, 3'd6, 64'hFFFF_FFFF_FFFF_8000, "lh64_o6");
    load64(3'b101, 3'd1, 64'h0000_0000_0000_FFFE, "lhu64_o1");

    // Counter wrap with CNT_W=4: 17 back-to-back instructions
    b_rst = 1'b1;
    tick();
    check("b_rst_ret", 64'(b_instret), 64'd0);
    b_rst = 1'b0; b_sel = 2'b00;
    for (int k = 1; k <= 18; k++) begin
      b_valid_mem = (k <= 17);
      tick();
      check("wrap_ret", 64'(b_instret), 64'((k - 1) % 16));
      if (k == 16) check("wrap_15", 64'(b_instret), 64'd15);
    end
    tick();
    check("wrap_final", 64'(b_instret), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
